// File: rtl/scalar_vector_mult_scheduler.sv
// Job-level controller for the scalar-vector float multiplier. It accepts a
// "multiply the next N lines by S" command and streams the lines into the
// multiplier. Results are buffered in a first-word-fall-through FIFO, and
// input credits are only issued while space is guaranteed for them. The
// final result line of each job is tagged with out_last.
module scalar_vector_mult_scheduler #(
  parameter int VALUES_PER_LINE = 16,
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_scalar,
  input  logic [31:0]                  cmd_num_lines,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*VALUES_PER_LINE-1:0] in_data,
  output logic [31:0]                  mult_scalar,
  output logic [32*VALUES_PER_LINE-1:0] mult_vector,
  output logic                         mult_trigger,
  input  logic [32*VALUES_PER_LINE-1:0] mult_result,
  input  logic                         mult_result_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [32*VALUES_PER_LINE-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         protocol_error
);

  localparam int W     = 32 * VALUES_PER_LINE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      scalar_q, scalar_d;
  logic [31:0]      num_lines_q, num_lines_d;
  logic [31:0]      issued_q, issued_d;
  logic [31:0]      received_q, received_d;
  logic [31:0]      fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mult_vector_q, mult_vector_d;
  logic             mult_trigger_q, mult_trigger_d;
  logic             protocol_error_q, protocol_error_d;

  // Each entry carries the result line plus its last-line tag in the MSB.
  logic [W:0]       fifo_mem [FIFO_DEPTH];

  logic [31:0] inflight;
  logic [32:0] credit_used;
  logic        fifo_empty;
  logic        in_ready_int;
  logic        push;
  logic        pop;
  logic        push_last;
  logic        head_last;
  logic        accept_cmd;
  logic        accept_line;

  // Handshake and credit terms; all derived from registered state. The
  // control outputs are qualified with reset so they read 0 while it is held.
  always_comb begin
    inflight     = issued_q - received_q;
    credit_used  = {1'b0, inflight} + {1'b0, fifo_count_q};
    fifo_empty   = (fifo_count_q == 32'd0);
    in_ready_int = (state_q == S_RUN) && (issued_q < num_lines_q) &&
                   (credit_used < 33'(FIFO_DEPTH));
    cmd_ready    = reset && (state_q == S_IDLE);
    in_ready     = reset && in_ready_int;
    out_valid    = reset && !fifo_empty;
    head_last    = fifo_mem[rd_ptr_q][W];
    out_data     = fifo_mem[rd_ptr_q][W-1:0];
    out_last     = out_valid && head_last;
    push         = mult_result_valid && (inflight != 32'd0);
    push_last    = (received_q + 32'd1 == num_lines_q);
    pop          = out_valid && out_ready;
    accept_cmd   = cmd_valid && cmd_ready;
    accept_line  = in_valid && in_ready;
    busy         = reset && (state_q != S_IDLE);
    done         = reset && (state_q == S_DONE);
    mult_trigger = reset && mult_trigger_q;
    protocol_error = reset && protocol_error_q;
    mult_scalar  = scalar_q;
    mult_vector  = mult_vector_q;
  end

  // Next-state logic for the job FSM, counters, FIFO pointers and the
  // multiplier drive registers.
  always_comb begin
    state_d          = state_q;
    scalar_d         = scalar_q;
    num_lines_d      = num_lines_q;
    issued_d         = issued_q;
    received_d       = received_q;
    fifo_count_d     = fifo_count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    mult_vector_d    = mult_vector_q;
    mult_trigger_d   = 1'b0;
    protocol_error_d = protocol_error_q;

    // A result with nothing outstanding is dropped and flagged.
    if (mult_result_valid && (inflight == 32'd0)) begin
      protocol_error_d = 1'b1;
    end
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      received_d = received_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fifo_count_d = fifo_count_q + {31'd0, push} - {31'd0, pop};

    case (state_q)
      S_IDLE: begin
        if (accept_cmd) begin
          scalar_d     = cmd_scalar;
          num_lines_d  = cmd_num_lines;
          issued_d     = 32'd0;
          received_d   = 32'd0;
          fifo_count_d = 32'd0;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          state_d      = (cmd_num_lines == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept_line) begin
          issued_d       = issued_q + 32'd1;
          mult_vector_d  = in_data;
          mult_trigger_d = 1'b1;
          if (issued_q + 32'd1 == num_lines_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Popping the tagged beat is what empties the FIFO at the end of a
        // job, so leaving on that pop gives done the cycle after it.
        if (pop && head_last && (received_q == num_lines_q)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      scalar_q         <= '0;
      num_lines_q      <= '0;
      issued_q         <= '0;
      received_q       <= '0;
      fifo_count_q     <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      mult_vector_q    <= '0;
      mult_trigger_q   <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      scalar_q         <= scalar_d;
      num_lines_q      <= num_lines_d;
      issued_q         <= issued_d;
      received_q       <= received_d;
      fifo_count_q     <= fifo_count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      mult_vector_q    <= mult_vector_d;
      mult_trigger_q   <= mult_trigger_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // Result FIFO storage; contents need no reset since occupancy is tracked.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem[wr_ptr_q] <= {push_last, mult_result};
    end
  end

endmodule
